// File: rtl/channel_filter.sv
// Per-channel input noise filter: bypass, half-cycle glitch rejection or counted debounce.
// Define FILTER_GLITCH_COUNT_EN to build the saturating rejected-glitch counter.
module channel_filter #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     dataInput,
  input  logic [WIDTH-1:0]     dataInput180,
  input  logic                 dataValid,
  input  logic [1:0]           filterMode,
  input  logic [CNT_WIDTH-1:0] holdCycles,
  input  logic                 glitchClear,
  output logic [WIDTH-1:0]     dataOutput,
  output logic                 validOut,
  output logic [15:0]          glitchCount
);

  typedef enum logic [1:0] {
    ModeBypass    = 2'b00,
    ModeHalfCycle = 2'b01,
    ModeDebounce  = 2'b10,
    ModeReserved  = 2'b11
  } filterMode_t;

  logic [1:0]           modePrev;
  logic                 modeChange;
  logic [WIDTH-1:0]     in360;
  logic [WIDTH-1:0]     in180d;
  logic [CNT_WIDTH-1:0] cnt     [WIDTH];
  logic [CNT_WIDTH-1:0] nextCnt [WIDTH];
  logic [WIDTH-1:0]     nextOutput;
  logic                 glitchSeen;

  assign modeChange = (filterMode != modePrev);

  // A mode switch freezes the output for one cycle and restarts every filter from scratch.
  always_comb begin
    nextOutput = dataOutput;
    nextCnt    = cnt;
    glitchSeen = 1'b0;
    if (modeChange) begin
      for (int i = 0; i < WIDTH; i++) nextCnt[i] = '0;
    end else begin
      case (filterMode_t'(filterMode))
        ModeHalfCycle: nextOutput = (dataOutput | in360 | dataInput) & in180d;
        ModeDebounce: begin
          if (dataValid) begin
            for (int i = 0; i < WIDTH; i++) begin
              if (dataInput[i] == dataOutput[i]) begin
                nextCnt[i] = '0;
                if (cnt[i] != '0) glitchSeen = 1'b1;
              end else if (cnt[i] >= holdCycles) begin
                nextOutput[i] = dataInput[i];
                nextCnt[i]    = '0;
              end else begin
                nextCnt[i] = cnt[i] + 1'b1;
              end
            end
          end
        end
        default: if (dataValid) nextOutput = dataInput;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      modePrev   <= ModeBypass;
      dataOutput <= '0;
      validOut   <= 1'b0;
      in360      <= '0;
      in180d     <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      modePrev   <= filterMode;
      dataOutput <= nextOutput;
      validOut   <= dataValid;
      cnt        <= nextCnt;
      // Half-cycle delay taps only track the inputs while that mode is active.
      if (modeChange) begin
        in360  <= '0;
        in180d <= '0;
      end else if (filterMode == ModeHalfCycle) begin
        in360  <= dataInput;
        in180d <= dataInput180;
      end
    end
  end

`ifdef FILTER_GLITCH_COUNT_EN
  logic [15:0] glitchReg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      glitchReg <= '0;
    end else if (glitchClear) begin
      glitchReg <= '0;
    end else if (glitchSeen && (glitchReg != 16'hFFFF)) begin
      glitchReg <= glitchReg + 16'd1;
    end
  end

  assign glitchCount = glitchReg;
`else
  logic unusedSignals;
  assign unusedSignals = glitchClear ^ glitchSeen;
  assign glitchCount   = '0;
`endif

endmodule

// File: doc/channel_filter.md
# channel_filter

Parametrised per-channel input noise filter for the sampler front end, placed between the input synchronisers and the trigger/sampler stages. It succeeds the fixed 32-channel half-cycle glitch filter with a generic channel count and a runtime mode select (bypass, half-cycle glitch rejection, or counted debounce with programmable hold length). An optional rejected-glitch counter is available for diagnostics.

## Interface
- WIDTH, 32: number of channels.
- CNT_WIDTH, 4: width of the per-channel debounce counter and of holdCycles.
- clock  input  1  sample clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- dataInput  input  WIDTH  synchronised channel samples.
- dataInput180  input  WIDTH  the same channels sampled on the falling edge; used only in mode 01.
- dataValid  input  1  qualifies dataInput for modes 00 and 10.
- filterMode  input  2  00 bypass, 01 half-cycle, 10 debounce, 11 reserved (behaves as 00).
- holdCycles  input  CNT_WIDTH  debounce length N; a new level must persist for N+1 valid samples.
- glitchClear  input  1  synchronous clear of glitchCount.
- dataOutput  output  WIDTH  filtered channels, registered.
- validOut  output  1  dataValid delayed by one cycle.
- glitchCount  output  16  saturating count of cycles in which at least one pulse was rejected.

## Operation
- Reset: dataOutput=0, validOut=0, glitchCount=0. All counters and internal delay registers are cleared.
- validOut <= dataValid in every mode.
- Mode 00/11: when dataValid=1, dataOutput <= dataInput. When dataValid=0, dataOutput holds.
- Mode 01 runs every clock and ignores dataValid:
  - result <= (result | in360 | dataInput) & in180d
  - in360 <= dataInput; in180d <= dataInput180
  - dataOutput = result
- Mode 10: per channel i, updated only when dataValid=1:
  - If dataInput[i]==dataOutput[i]: cnt[i]<=0. If cnt[i]!=0, the channel is a rejected glitch.
  - Else if cnt[i] >= holdCycles: dataOutput[i]<=dataInput[i], cnt[i]<=0.
  - Else cnt[i]<=cnt[i]+1.
- With holdCycles=0, mode 10 behaves identically to mode 00.
- Raising holdCycles mid-count extends the count. Lowering it below cnt[i] commits the channel on its next differing valid sample; the >= compare covers this case.
- When filterMode differs from its value on the previous cycle:
  - all cnt[] and the mode-01 delay registers are cleared;
  - dataOutput keeps its value;
  - no glitch is counted in that cycle.
- The counter never wraps: cnt is at most 2^CNT_WIDTH-1.

## Timing
- Latency: 1 clock from dataInput to dataOutput in mode 00. Mode 01 has 1–2 clocks.
- In mode 10, a change is visible on dataOutput 1 clock after the (N+1)th consecutive valid differing sample.
- Samples with dataValid=0 neither advance nor reset cnt, so non-valid cycles do not break a run.
- Reset is asynchronous on assertion. Deassertion is expected synchronous to clock (handled upstream). Asserting reset mid-count discards all progress.

## Configuration
- FILTER_GLITCH_COUNT_EN defined:
  - glitchCount increments by 1, saturating at 0xFFFF, in any mode-10 cycle where at least one channel rejects a glitch.
  - glitchClear=1 forces 0; clear wins over a simultaneous increment.
- FILTER_GLITCH_COUNT_EN undefined:
  - glitchCount is tied to 0 and glitchClear is ignored.
  - No counter logic is synthesised.

## Test plan
- Reset, then mode 00 with dataValid=1 and dataInput=0xA5A5A5A5 -> dataOutput=0xA5A5A5A5 and validOut=1 one clock later. Asserting reset mid-stream -> all outputs 0 immediately.
- Mode 01, channel 0: a 1 appears on dataInput only while dataInput180 stays 0 -> output stays 0. A 1 held on both inputs for 2 clocks -> output 1.
- Mode 10, N=3, channel 5 steps 0→1 with continuous valid -> dataOutput[5] rises 1 clock after the 4th sample. A 3-sample pulse -> output unchanged and glitchCount=1 (macro on).
- Mode 10, N=3: a 4-sample high run with dataValid=0 gaps interleaved -> still accepted. Changing N to 1 at cnt=2 -> commit on the next differing valid sample.
- Macro on: 70000 glitch cycles -> glitchCount=0xFFFF. glitchClear together with a glitch -> 0. Macro off -> glitchCount always 0.
- Switching the mode 10→00 while cnt≠0 -> counters cleared, dataOutput unchanged that cycle, no glitch counted.
